// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle control unit: state codes, ALU/PC selects,
// exception causes and the OpCode/Funct values it decodes.
package cpu_pkg;

  typedef logic [6:0] state_t;

  localparam state_t S_RESET   = 7'd0;
  localparam state_t S_FETCH   = 7'd1;
  localparam state_t S_MEMWAIT = 7'd2;
  localparam state_t S_IRLOAD  = 7'd3;
  localparam state_t S_DECODE  = 7'd4;
  localparam state_t S_EXEC_R  = 7'd5;
  localparam state_t S_EXEC_I  = 7'd6;
  localparam state_t S_WB_R    = 7'd7;
  localparam state_t S_WB_I    = 7'd8;
  localparam state_t S_BRANCH  = 7'd9;
  localparam state_t S_BREAK   = 7'd10;
  localparam state_t S_RTE     = 7'd11;
  localparam state_t S_EXC     = 7'd12;
  localparam state_t S_EXC_VEC = 7'd13;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_AND  = 3'd3;

  localparam logic [2:0] PC_ALU    = 3'd0;
  localparam logic [2:0] PC_ALUOUT = 3'd1;
  localparam logic [2:0] PC_EPC    = 3'd3;
  localparam logic [2:0] PC_EXCVEC = 3'd4;

  localparam logic [1:0] EXC_NONE = 2'd0;
  localparam logic [1:0] EXC_OVF  = 2'd1;
  localparam logic [1:0] EXC_ILL  = 2'd2;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [5:0] FN_BREAK = 6'h0D;
  localparam logic [5:0] FN_RTE   = 6'h13;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;

  // Only add and sub can raise a signed-overflow exception.
  function automatic logic is_arith_op(input logic [2:0] alu_op);
    return (alu_op == ALU_ADD) || (alu_op == ALU_SUB);
  endfunction

endpackage

// File: rtl/control_unit_mc_if.sv
// Decode/status inputs and datapath control outputs of the control unit.
// master = control unit side, slave = datapath side.
interface control_unit_mc_if;
  logic [5:0] OpCode;
  logic [5:0] Funct;
  logic       Overflow;
  logic       Zero;
  logic [1:0] ALUSrcA;
  logic [2:0] ALUSrcB;
  logic [2:0] ALUOp;
  logic [2:0] PCSource;
  logic       PCWrite;
  logic       IRWrite;
  logic       WriteAB;
  logic       ALUOutControl;
  logic       RegWrite;
  logic       EPCWrite;
  logic [1:0] RegDst;
  logic [1:0] ExcCause;
  logic [6:0] stateout;

  modport master (
    input  OpCode, Funct, Overflow, Zero,
    output ALUSrcA, ALUSrcB, ALUOp, PCSource, PCWrite, IRWrite, WriteAB,
           ALUOutControl, RegWrite, EPCWrite, RegDst, ExcCause, stateout
  );

  modport slave (
    output OpCode, Funct, Overflow, Zero,
    input  ALUSrcA, ALUSrcB, ALUOp, PCSource, PCWrite, IRWrite, WriteAB,
           ALUOutControl, RegWrite, EPCWrite, RegDst, ExcCause, stateout
  );
endinterface

// File: rtl/wait_counter.sv
// Loadable 3-bit down-counter; o_done is high while the count is zero.
module wait_counter (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       i_load,
  input  logic [2:0] i_load_val,
  input  logic       i_dec,
  output logic       o_done
);

  logic [2:0] r_count;

  // Count register: load has priority over decrement, never wraps below zero.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= 3'd0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != 3'd0)) begin
      r_count <= r_count - 3'd1;
    end else begin
      r_count <= r_count;
    end
  end

  assign o_done = (r_count == 3'd0);

endmodule

// File: rtl/control_unit_mc.sv
// Multi-cycle Moore control unit: fetch, parameterised memory wait, decode,
// execute/writeback, branches, break/rte and overflow/illegal-opcode exceptions.
module control_unit_mc
  import cpu_pkg::*;
#(
  parameter int MEM_WAIT = 2,
  parameter int EXC_EN   = 1
) (
  input  logic clock,
  input  logic reset_n,
  control_unit_mc_if.master cu
);

  // The counter is loaded in FETCH so MEMWAIT sees MEM_WAIT-1 .. 0.
  localparam logic [2:0] WAIT_LOAD = 3'(MEM_WAIT - 1);
  localparam logic       EXC_ON    = (EXC_EN != 0);

  state_t     r_state;
  logic [2:0] r_alu_op;
  logic       r_br_ne;
  logic [1:0] r_exc_cause;

  state_t     w_next_state;
  state_t     w_dec_next;
  logic [2:0] w_dec_alu_op;
  logic       w_dec_br_ne;
  logic [1:0] w_cause_next;
  logic       w_ovf_trap;
  logic       w_wait_load;
  logic       w_wait_dec;
  logic       w_wait_done;

  logic [1:0] w_alu_src_a;
  logic [2:0] w_alu_src_b;
  logic [2:0] w_alu_op;
  logic [2:0] w_pc_source;
  logic       w_pc_write;
  logic       w_ir_write;
  logic       w_write_ab;
  logic       w_alu_out_ctl;
  logic       w_reg_write;
  logic       w_epc_write;
  logic [1:0] w_reg_dst;
  logic [1:0] w_exc_cause;

  assign w_wait_load = (r_state == S_FETCH);
  assign w_wait_dec  = (r_state == S_MEMWAIT) && !w_wait_done;

  wait_counter u_wait_counter (
    .clock      (clock),
    .reset_n    (reset_n),
    .i_load     (w_wait_load),
    .i_load_val (WAIT_LOAD),
    .i_dec      (w_wait_dec),
    .o_done     (w_wait_done)
  );

  // Instruction decode: dispatch target plus the ALU op / branch sense to latch.
  always_comb begin
    w_dec_next   = S_EXC;
    w_dec_alu_op = ALU_ADD;
    w_dec_br_ne  = 1'b0;
    case (cu.OpCode)
      OP_RTYPE: begin
        case (cu.Funct)
          FN_ADD:   begin w_dec_next = S_EXEC_R; w_dec_alu_op = ALU_ADD; end
          FN_SUB:   begin w_dec_next = S_EXEC_R; w_dec_alu_op = ALU_SUB; end
          FN_AND:   begin w_dec_next = S_EXEC_R; w_dec_alu_op = ALU_AND; end
          FN_BREAK: w_dec_next = S_BREAK;
          FN_RTE:   w_dec_next = S_RTE;
          default:  w_dec_next = S_EXC;
        endcase
      end
      OP_ADDI: w_dec_next = S_EXEC_I;
      OP_BEQ:  begin w_dec_next = S_BRANCH; w_dec_br_ne = 1'b0; end
      OP_BNE:  begin w_dec_next = S_BRANCH; w_dec_br_ne = 1'b1; end
      default: w_dec_next = S_EXC;
    endcase
  end

  // Overflow trap condition for the two execute states.
  always_comb begin
    if (EXC_ON && cu.Overflow) begin
      w_ovf_trap = ((r_state == S_EXEC_R) && is_arith_op(r_alu_op)) ||
                   (r_state == S_EXEC_I);
    end else begin
      w_ovf_trap = 1'b0;
    end
  end

  // Next-state logic and the exception cause captured on entry to EXC.
  always_comb begin
    w_next_state = S_RESET;
    w_cause_next = r_exc_cause;
    case (r_state)
      S_RESET:   w_next_state = S_FETCH;
      S_FETCH:   w_next_state = S_MEMWAIT;
      S_MEMWAIT: w_next_state = w_wait_done ? S_IRLOAD : S_MEMWAIT;
      S_IRLOAD:  w_next_state = S_DECODE;
      S_DECODE: begin
        w_next_state = w_dec_next;
        if (w_dec_next == S_EXC) begin
          w_cause_next = EXC_ILL;
        end else begin
          w_cause_next = r_exc_cause;
        end
      end
      S_EXEC_R, S_EXEC_I: begin
        if (w_ovf_trap) begin
          w_next_state = S_EXC;
          w_cause_next = EXC_OVF;
        end else begin
          w_next_state = (r_state == S_EXEC_R) ? S_WB_R : S_WB_I;
        end
      end
      S_EXC:     w_next_state = S_EXC_VEC;
      S_WB_R, S_WB_I, S_BRANCH, S_BREAK, S_RTE, S_EXC_VEC:
                 w_next_state = S_FETCH;
      default:   w_next_state = S_RESET;
    endcase
  end

  // State, latched decode results and exception cause.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_RESET;
      r_alu_op    <= ALU_PASS;
      r_br_ne     <= 1'b0;
      r_exc_cause <= EXC_NONE;
    end else begin
      r_state     <= w_next_state;
      r_exc_cause <= w_cause_next;
      if (r_state == S_DECODE) begin
        r_alu_op <= w_dec_alu_op;
        r_br_ne  <= w_dec_br_ne;
      end else begin
        r_alu_op <= r_alu_op;
        r_br_ne  <= r_br_ne;
      end
    end
  end

  // Moore output decode; everything not named for a state stays zero.
  always_comb begin
    w_alu_src_a   = 2'd0;
    w_alu_src_b   = 3'd0;
    w_alu_op      = ALU_PASS;
    w_pc_source   = PC_ALU;
    w_pc_write    = 1'b0;
    w_ir_write    = 1'b0;
    w_write_ab    = 1'b0;
    w_alu_out_ctl = 1'b0;
    w_reg_write   = 1'b0;
    w_epc_write   = 1'b0;
    w_reg_dst     = 2'd0;
    w_exc_cause   = EXC_NONE;
    case (r_state)
      S_RESET:   begin w_reg_dst = 2'd1; w_reg_write = 1'b1; end
      S_FETCH:   begin w_alu_src_b = 3'd1; w_alu_op = ALU_ADD; w_pc_write = 1'b1; end
      S_MEMWAIT: w_pc_write = 1'b0;
      S_IRLOAD:  w_ir_write = 1'b1;
      S_DECODE: begin
        w_write_ab = 1'b1; w_alu_src_b = 3'd3; w_alu_op = ALU_ADD; w_alu_out_ctl = 1'b1;
      end
      S_EXEC_R: begin
        w_alu_src_a = 2'd2; w_alu_src_b = 3'd0; w_alu_op = r_alu_op; w_alu_out_ctl = 1'b1;
      end
      S_EXEC_I: begin
        w_alu_src_a = 2'd2; w_alu_src_b = 3'd2; w_alu_op = ALU_ADD; w_alu_out_ctl = 1'b1;
      end
      S_WB_R:    begin w_reg_dst = 2'd3; w_reg_write = 1'b1; end
      S_WB_I:    begin w_reg_dst = 2'd0; w_reg_write = 1'b1; end
      S_BRANCH: begin
        w_alu_src_a = 2'd2; w_alu_src_b = 3'd0; w_alu_op = ALU_SUB; w_pc_source = PC_ALUOUT;
        w_pc_write  = r_br_ne ? !cu.Zero : cu.Zero;
      end
      S_BREAK:   begin w_alu_src_b = 3'd1; w_alu_op = ALU_SUB; w_pc_write = 1'b1; end
      S_RTE:     begin w_pc_source = PC_EPC; w_pc_write = 1'b1; end
      S_EXC: begin
        w_alu_src_b = 3'd1; w_alu_op = ALU_SUB; w_epc_write = 1'b1; w_exc_cause = r_exc_cause;
      end
      S_EXC_VEC: begin
        w_pc_source = PC_EXCVEC; w_pc_write = 1'b1; w_exc_cause = r_exc_cause;
      end
      default:   w_pc_write = 1'b0;
    endcase
  end

  assign cu.ALUSrcA       = w_alu_src_a;
  assign cu.ALUSrcB       = w_alu_src_b;
  assign cu.ALUOp         = w_alu_op;
  assign cu.PCSource      = w_pc_source;
  assign cu.PCWrite       = w_pc_write;
  assign cu.IRWrite       = w_ir_write;
  assign cu.WriteAB       = w_write_ab;
  assign cu.ALUOutControl = w_alu_out_ctl;
  assign cu.RegWrite      = w_reg_write;
  assign cu.EPCWrite      = w_epc_write;
  assign cu.RegDst        = w_reg_dst;
  assign cu.ExcCause      = w_exc_cause;
  assign cu.stateout      = r_state;

endmodule

// File: doc/control_unit_mc.md
CONTROL_UNIT_MC -- requirements
Module: control_unit_mc

Interface
REQ-001 SHALL have parameter MEM_WAIT, default 2, memory read wait cycles between fetch and IR load (legal 1..7).
REQ-002 SHALL have parameter EXC_EN, default 1, 1 = arithmetic overflow raises exception, 0 = Overflow ignored.
REQ-003 SHALL have port clock  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port OpCode  in  6  IR[31:26].
REQ-006 SHALL have port Funct  in  6  IR[5:0].
REQ-007 SHALL have port Overflow  in  1  ALU signed overflow.
REQ-008 SHALL have port Zero  in  1  ALU result zero.
REQ-009 SHALL have outputs ALUSrcA out 2 and ALUSrcB out 3, ALU operand selects.
REQ-010 SHALL have outputs ALUOp out 3 (0 pass, 1 add, 2 sub, 3 and) and PCSource out 3 (0 ALU, 1 ALUOut, 3 EPC, 4 exception vector).
REQ-011 SHALL have 1-bit outputs PCWrite, IRWrite, WriteAB (A/B load), ALUOutControl, RegWrite and EPCWrite.
REQ-012 SHALL have outputs RegDst out 2 (0 rt, 1 sp, 3 rd), ExcCause out 2 (0 none, 1 overflow, 2 illegal opcode) and stateout out 7 (current state code).

Function
REQ-013 SHALL be a Moore FSM; every output not listed for a state SHALL be 0.
REQ-014 SHALL implement RESET with RegDst=1 and RegWrite=1, then FETCH.
REQ-015 SHALL implement FETCH with ALUSrcB=1, ALUOp=1 and PCWrite=1 (PC+4), then MEMWAIT.
REQ-016 SHALL hold MEMWAIT exactly MEM_WAIT cycles using a 3-bit down-counter loaded on entry, then IRLOAD.
REQ-017 SHALL implement IRLOAD with IRWrite=1, then DECODE.
REQ-018 SHALL implement DECODE with WriteAB=1, ALUSrcB=3, ALUOp=1 and ALUOutControl=1 (branch target).
REQ-019 SHALL dispatch from DECODE on OpCode 0 / Funct: 0x20 add, 0x22 sub and 0x24 and -> EXEC_R; 0x0D -> BREAK; 0x13 -> RTE.
REQ-020 SHALL dispatch from DECODE on OpCode: 0x08 -> EXEC_I; 0x04 beq and 0x05 bne -> BRANCH; any other OpCode/Funct -> EXC with cause 2.
REQ-021 SHALL latch the decoded ALUOp and branch sense in DECODE into a register held until the next DECODE.
REQ-022 SHALL implement EXEC_R with ALUSrcA=2, ALUSrcB=0, ALUOp=latched value and ALUOutControl=1.
REQ-023 SHALL go from EXEC_R to EXC (cause 1) when EXC_EN=1, Overflow=1 and ALUOp is add or sub, and to WB_R otherwise.
REQ-024 SHALL implement EXEC_I with ALUSrcA=2, ALUSrcB=2, ALUOp=1 and ALUOutControl=1, with the same overflow rule, then WB_I.
REQ-025 SHALL implement WB_R with RegDst=3 and RegWrite=1, and WB_I with RegDst=0 and RegWrite=1; both then FETCH.
REQ-026 SHALL implement BRANCH with ALUSrcA=2, ALUSrcB=0, ALUOp=2, PCSource=1 and PCWrite=Zero (beq) or !Zero (bne), then FETCH.
REQ-027 SHALL implement BREAK with ALUSrcB=1, ALUOp=2 and PCWrite=1 (PC-4), then FETCH; the core re-fetches the break (halt loop).
REQ-028 SHALL implement RTE with PCSource=3 and PCWrite=1, then FETCH.
REQ-029 SHALL implement EXC with ALUSrcB=1, ALUOp=2 and EPCWrite=1 (EPC=faulting PC), then EXC_VEC with PCSource=4 and PCWrite=1, then FETCH.
REQ-030 SHALL register ExcCause on entry to EXC, drive it in EXC and EXC_VEC, and drive 0 elsewhere.
REQ-031 SHALL suppress RegWrite on overflow (no writeback of the faulting result).
REQ-032 SHALL drive stateout combinationally from the state register, with no extra cycle of lag.

Reset
REQ-033 SHALL, while reset_n=0, force state RESET, clear the wait counter, latched ALUOp and ExcCause, and drive RESET outputs asynchronously.
REQ-034 SHALL abort any instruction in progress on reset_n assertion, with no PC, register or EPC write committed afterwards.
REQ-035 SHALL leave RESET on the first rising edge after reset_n deasserts.

Structure
REQ-036 SHALL take the state enum (7-bit codes), ALUOp, PCSource and ExcCause constants, and OpCode/Funct values from shared package cpu_pkg.
REQ-037 SHALL contain a single sub-module, wait_counter (loadable 3-bit down-counter with done flag).

Verification
REQ-038 SHALL verify add, MEM_WAIT=3: reset then OpCode 0, Funct 0x20, Overflow 0 -> FETCH, 3x MEMWAIT, IRLOAD, DECODE, EXEC_R, WB_R (RegDst=3, RegWrite=1), FETCH.
REQ-039 SHALL verify overflow: addi with Overflow=1 in EXEC_I -> EXC (EPCWrite=1, ExcCause=1), EXC_VEC (PCSource=4, PCWrite=1), no RegWrite; with EXC_EN=0 -> WB_I.
REQ-040 SHALL verify illegal opcode: OpCode 0x3F -> EXC with ExcCause=2 directly after DECODE.
REQ-041 SHALL verify branches: beq with Zero=1 -> PCWrite=1, PCSource=1; bne with Zero=1 -> PCWrite=0; both return to FETCH.
REQ-042 SHALL verify reset: reset_n pulled low in MEMWAIT and in EXC -> stateout=RESET immediately, EPCWrite=0, restart fetch after release.
